// File: rtl/wb_trace_pkg.sv
// Shared definitions for the write-back trace buffer: event layout and packing.
package wb_trace_pkg;

  localparam int unsigned TRACE_W  = 50;
  localparam int unsigned OVF_BIT  = 49;
  localparam int unsigned PC_LSB   = 37;
  localparam int unsigned PC_W     = 12;
  localparam int unsigned RD_LSB   = 32;
  localparam int unsigned RD_W     = 5;
  localparam int unsigned DATA_LSB = 0;
  localparam int unsigned DATA_W   = 32;

  function automatic logic [TRACE_W-1:0] pack_event(
    input logic              ovf,
    input logic [PC_W-1:0]   pc,
    input logic [RD_W-1:0]   rd,
    input logic [DATA_W-1:0] data
  );
    logic [TRACE_W-1:0] ev;
    ev                     = '0;
    ev[OVF_BIT]            = ovf;
    ev[PC_LSB +: PC_W]     = pc;
    ev[RD_LSB +: RD_W]     = rd;
    ev[DATA_LSB +: DATA_W] = data;
    return ev;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push into a full FIFO is taken
// only when a pop happens on the same edge.
module sync_fifo #(
  parameter  int unsigned WIDTH = 50,
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Captures regfile write-back events into a FIFO and drains them over a
// valid/ready stream, counting events lost to a full buffer.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned DROP_R0 = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ctrl_writeEnable,
  input  logic [4:0]         ctrl_writeReg,
  input  logic [31:0]        data_writeReg,
  input  logic [11:0]        address_imem,
  input  logic               overflow,
  output logic               trace_valid,
  input  logic               trace_ready,
  output logic [TRACE_W-1:0] trace_data,
  output logic [15:0]        drop_count,
  output logic               dropped
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [1:0]  rst_sync;
  logic        active;
  logic        push_req;
  logic        pop;
  logic        drop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count_unused;

  // Captures stay off until reset release has passed through two flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign active   = rst_sync[1];
  assign push_req = active & ctrl_writeEnable &
                    ~((DROP_R0 != 0) && (ctrl_writeReg == '0));
  assign pop      = trace_ready & ~fifo_empty;
  assign drop     = push_req & fifo_full & ~pop;

  assign trace_valid = ~fifo_empty;

  sync_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_req),
    .push_data (pack_event(overflow, address_imem, ctrl_writeReg, data_writeReg)),
    .pop       (pop),
    .pop_data  (trace_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count_unused)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      drop_count <= '0;
      dropped    <= 1'b0;
    end else if (drop) begin
      if (drop_count != '1) drop_count <= drop_count + 1'b1;
      dropped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (DEPTH=8).
module tb_wb_trace_buffer;

  logic        clock = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  wreg;
  logic [31:0] wdata;
  logic [11:0] pc;
  logic        ovf;
  logic        ready;

  logic        valid,  valid0;
  logic [49:0] data,   data0;
  logic [15:0] dcount, dcount0;
  logic        dflag,  dflag0;

  int passed = 0;
  int total  = 0;

  logic [49:0] q[$];
  logic [49:0] held;
  logic        held_v;
  logic        do_push;
  int          n;

  always #5 clock = ~clock;

  wb_trace_buffer #(.DEPTH(8), .DROP_R0(1)) dut (
    .clock(clock), .reset(reset), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
    .data_writeReg(wdata), .address_imem(pc), .overflow(ovf),
    .trace_valid(valid), .trace_ready(ready), .trace_data(data),
    .drop_count(dcount), .dropped(dflag)
  );

  wb_trace_buffer #(.DEPTH(8), .DROP_R0(0)) dut0 (
    .clock(clock), .reset(reset), .ctrl_writeEnable(we), .ctrl_writeReg(wreg),
    .data_writeReg(wdata), .address_imem(pc), .overflow(ovf),
    .trace_valid(valid0), .trace_ready(1'b1), .trace_data(data0),
    .drop_count(dcount0), .dropped(dflag0)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [49:0] ev(input int k);
    logic [11:0] p;
    logic [4:0]  r;
    logic [31:0] d;
    p = 12'(k * 3 + 1);
    r = 5'((k % 31) + 1);
    d = 32'hC0DE_0000 + 32'(k);
    return {k[0], p, r, d};
  endfunction

  task automatic write_ev(input int k);
    we    = 1'b1;
    ovf   = k[0];
    pc    = 12'(k * 3 + 1);
    wreg  = 5'((k % 31) + 1);
    wdata = 32'hC0DE_0000 + 32'(k);
  endtask

  initial begin
    reset = 1'b0; we = 1'b0; wreg = '0; wdata = '0; pc = '0; ovf = 1'b0; ready = 1'b0;
    held = '0; held_v = 1'b0; n = 0;

    #3;
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_drop_count", dcount, 0);
    check("rst_dropped", dflag, 0);

    @(posedge clock); #3 reset = 1'b1;
    repeat (3) cyc();

    // Single write
    ready = 1'b1;
    we = 1'b1; wreg = 5'd5; wdata = 32'hDEADBEEF; pc = 12'h010; ovf = 1'b0;
    cyc();
    we = 1'b0;
    check("single_valid", valid, 1);
    check("single_data", data, {1'b0, 12'h010, 5'd5, 32'hDEADBEEF});
    cyc();
    check("single_valid_after", valid, 0);

    // R0 filter
    we = 1'b1; wreg = 5'd0; wdata = 32'h1234_5678; pc = 12'h020; ovf = 1'b1;
    cyc();
    we = 1'b0;
    check("r0_valid", valid, 0);
    check("r0_drop_count", dcount, 0);
    check("r0_nofilter_valid", valid0, 1);
    check("r0_nofilter_data", data0, {1'b1, 12'h020, 5'd0, 32'h12345678});
    cyc();
    check("r0_valid_later", valid, 0);

    // Fill and overflow
    ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      write_ev(k);
      cyc();
      if (k == 7) check("fill_no_drop_yet", {dflag, dcount}, 0);
      if (k == 8) check("fill_first_drop", {dflag, dcount}, {1'b1, 16'd1});
    end
    we = 1'b0;
    check("fill_drop_count", dcount, 2);
    check("fill_dropped", dflag, 1);
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", valid, 1);
      check("drain_data", data, ev(i));
      cyc();
    end
    check("drain_empty", valid, 0);
    check("nofilter_no_drops", {dflag0, dcount0}, 0);
    ready = 1'b0;

    // Full with simultaneous push and pop
    for (int k = 100; k < 108; k++) begin
      write_ev(k);
      cyc();
    end
    check("full_no_drop", dcount, 2);
    ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      write_ev(108 + i);
      check("pushpop_data", data, ev(100 + i));
      cyc();
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("pushpop_tail", data, ev(120 + i));
      cyc();
    end
    check("pushpop_empty", valid, 0);
    check("pushpop_drop_count", dcount, 2);

    // Backpressure with random ready
    for (int c = 0; c < 60; c++) begin
      ready = 1'($urandom_range(0, 1));
      do_push = (q.size() < 6) && ($urandom_range(0, 1) == 1);
      if (do_push) write_ev(200 + n);
      else we = 1'b0;
      check("bp_valid", valid, q.size() != 0);
      if (q.size() != 0) check("bp_data", data, q[0]);
      if (held_v) check("bp_stable", {valid, data}, {1'b1, held});
      held_v = valid && !ready;
      held   = data;
      if (ready && q.size() != 0) void'(q.pop_front());
      if (do_push) begin
        q.push_back(ev(200 + n));
        n++;
      end
      cyc();
    end
    we = 1'b0; ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (q.size() != 0) begin
        check("bp_drain", data, q[0]);
        void'(q.pop_front());
      end
      cyc();
    end
    check("bp_empty", valid, 0);
    check("bp_drop_count", dcount, 2);

    // Async reset mid-drain
    ready = 1'b0;
    for (int k = 300; k < 304; k++) begin
      write_ev(k);
      cyc();
    end
    we = 1'b0;
    check("pre_rst_valid", valid, 1);
    check("pre_rst_dropped", dflag, 1);
    #3 reset = 1'b0;
    #1;
    check("arst_valid", valid, 0);
    check("arst_drop_count", dcount, 0);
    check("arst_dropped", dflag, 0);
    check("arst_data", data, 0);
    @(posedge clock); #3 reset = 1'b1;
    repeat (3) cyc();
    ready = 1'b1;
    write_ev(400);
    cyc();
    we = 1'b0;
    check("post_rst_valid", valid, 1);
    check("post_rst_data", data, ev(400));
    cyc();
    check("post_rst_only", valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
